scan_sel_gen: RTL

- Upstream stage of the 2-to-4 select decoder.
- Generates the 2-bit select pair (A1:A0) that the decoder turns into one-hot D0..D3 lines.
- Cycles the select at a prescaled rate (display/row scanning), with hold, single-step and direct-load control.
- Sits between board-level control (switches/buttons, already debounced) and the decoder.

---
 rtl/scan_sel_gen_pkg.sv | 31 +++
 rtl/scan_sel_gen_if.sv | 29 ++
 rtl/scan_sel_gen_prescaler.sv | 32 +++
 rtl/scan_sel_gen.sv | 110 +++++++++++
 4 files changed

// File: rtl/scan_sel_gen_pkg.sv
// scan_pkg: shared encodings and constants for the scan select generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;

  localparam logic [1:0] SEL_MAX = 2'd3;

  // Number of cycles the decoded lines are blanked after a select change.
  localparam int BLANK_CYC = 2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_STEP = S_STEP
  } scan_state_t;

  // Next select value, modulo 4, in the requested direction.
  function automatic logic [1:0] sel_next(input logic [1:0] sel, input logic down);
    return down ? (sel - 2'd1) : (sel + 2'd1);
  endfunction

  // True when the advance from sel in the requested direction crosses 3<->0.
  function automatic logic sel_crosses(input logic [1:0] sel, input logic down);
    return down ? (sel == 2'd0) : (sel == SEL_MAX);
  endfunction

endpackage

// File: rtl/scan_sel_gen_if.sv
// scan_sel_gen_if: control inputs and select outputs of the scan select generator.
// Latency: n/a (wiring only); blank exists only when SCAN_BLANK_EN is defined.
// Backpressure: none; all signals are level/pulse, sampled every cycle.
interface scan_sel_gen_if;

  logic       en;
  logic       dir;
  logic       step;
  logic       load;
  logic [1:0] load_sel;
  logic       A0;
  logic       A1;
  logic       tick;
  logic       wrap;
`ifdef SCAN_BLANK_EN
  logic       blank;

  modport master (output en, dir, step, load, load_sel,
                  input  A0, A1, tick, wrap, blank);
  modport slave  (input  en, dir, step, load, load_sel,
                  output A0, A1, tick, wrap, blank);
`else
  modport master (output en, dir, step, load, load_sel,
                  input  A0, A1, tick, wrap);
  modport slave  (input  en, dir, step, load, load_sel,
                  output A0, A1, tick, wrap);
`endif

endinterface

// File: rtl/scan_sel_gen_prescaler.sv
// scan_prescaler: divides clk by CLK_DIV while run is high; tc marks the last count.
// Latency: tc is decoded from the count register, high in the CLK_DIV-th run cycle.
// Backpressure: none; clr or !run zeroes the count at the next edge.
module scan_prescaler #(
  parameter int CLK_DIV = 100000,
  parameter int DIV_W   = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tc
);

  localparam logic [DIV_W-1:0] TC_VAL = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tc = run && (cnt == TC_VAL);

  // Count only while running; leaving run or a clear restarts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: prescaled 2-bit scan select with hold/step/load; SCAN_BLANK_EN adds a blank output.
// Latency: run advances every CLK_DIV cycles; step pulse -> advance 2 edges later; load -> next edge.
// Backpressure: none; control pulses are sampled every cycle, load beats advance and step.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int DIV_W   = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_sel_gen_if.slave  bus
);

  scan_state_t state;
  logic [1:0]  sel;
  logic        tick_q;
  logic        wrap_q;
  logic        tc;
  logic        run;
  logic        adv;

  assign run = (state == ST_RUN);

  // A pending step always advances; in run the prescaler terminal count does.
  assign adv = tc || (state == ST_STEP);

  scan_prescaler #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clr   (bus.load),
    .tc    (tc)
  );

  // Mode FSM plus the select register and its one-cycle flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sel    <= 2'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.load) begin
        // Load wins: no flags, any pending step is dropped.
        sel   <= bus.load_sel;
        state <= bus.en ? ST_RUN : ST_IDLE;
      end else begin
        if (adv) begin
          sel    <= sel_next(sel, bus.dir);
          tick_q <= 1'b1;
          wrap_q <= sel_crosses(sel, bus.dir);
        end
        case (state)
          ST_IDLE: begin
            if (bus.en) begin
              state <= ST_RUN;
            end else if (bus.step) begin
              state <= ST_STEP;
            end
          end
          ST_RUN: begin
            if (!bus.en) begin
              state <= ST_IDLE;
            end
          end
          ST_STEP: begin
            state <= bus.en ? ST_RUN : ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.A0   = sel[0];
  assign bus.A1   = sel[1];
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

`ifdef SCAN_BLANK_EN
  logic       blank_q;
  logic [1:0] blank_rem;

  // Hold blank for BLANK_CYC cycles from each select change and out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q   <= 1'b1;
      blank_rem <= 2'(BLANK_CYC - 1);
    end else if (bus.load || adv) begin
      blank_q   <= 1'b1;
      blank_rem <= 2'(BLANK_CYC - 1);
    end else if (blank_rem != 2'd0) begin
      blank_rem <= blank_rem - 2'd1;
    end else begin
      blank_q   <= 1'b0;
    end
  end

  assign bus.blank = blank_q;
`endif

endmodule
